// File: rtl/counter_ctl.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctl
// Description : Parametrised loadable up/down timer/counter channel with
//               programmable prescaler, wrap / saturate / one-shot terminal
//               behaviour, registered compare-match, load-accept pulse and a
//               registered bus-drive enable that blocks loads while driving.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ctl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [WIDTH-1:0] in_load_value,
    input  logic             in_load_now,
    input  logic             in_write_now,
    input  logic             in_enable,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic [PRE_W-1:0] in_prescale,
    input  logic [WIDTH-1:0] in_compare,
    output logic [WIDTH-1:0] out_counter_value,
    output logic [WIDTH-1:0] out_ena,
    output logic             out_terminal,
    output logic             out_match,
    output logic             out_done,
    output logic             out_load_ack
);

    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};

    localparam logic [1:0] MODE_WRAP     = 2'b00;
    localparam logic [1:0] MODE_SATURATE = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre;

    logic             bus_driving;
    logic             load_accept;
    logic             freeze;
    logic             prescale_hit;
    logic [WIDTH-1:0] terminal_value;
    logic             at_terminal;
    logic [WIDTH-1:0] stepped_value;

    // The bus is considered driven from the registered enable, not the request,
    // so a load can only land once the drive has actually been released.
    assign bus_driving    = |out_ena;
    assign load_accept    = in_load_now & ~bus_driving;
    assign freeze         = in_load_now &  bus_driving;
    assign prescale_hit   = (pre == in_prescale);
    assign terminal_value = in_dir ? CNT_MAX : CNT_ZERO;
    assign at_terminal    = (out_counter_value == terminal_value);
    // Plain modular step; at the terminal value this is exactly the wrap result.
    assign stepped_value  = in_dir ? (out_counter_value + CNT_ONE)
                                   : (out_counter_value - CNT_ONE);

    // Control FSM, prescaler, counter register and all registered outputs.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state             <= ST_STOP;
            pre               <= PRE_ZERO;
            out_counter_value <= CNT_ZERO;
            out_ena           <= CNT_ZERO;
            out_terminal      <= 1'b0;
            out_match         <= 1'b0;
            out_done          <= 1'b0;
            out_load_ack      <= 1'b0;
        end else begin
            // Outputs refreshed every cycle regardless of state.
            out_ena      <= {WIDTH{in_write_now & ~in_load_now}};
            out_match    <= (out_counter_value == in_compare);
            out_terminal <= 1'b0;
            out_load_ack <= 1'b0;
            out_done     <= 1'b0;

            if (load_accept) begin
                // An accepted load wins over any tick and leaves DONE.
                out_counter_value <= in_load_value;
                pre               <= PRE_ZERO;
                out_load_ack      <= 1'b1;
                state             <= in_enable ? ST_RUN : ST_STOP;
            end else begin
                case (state)
                    ST_STOP: begin
                        pre <= PRE_ZERO;
                        if (in_enable) begin
                            state <= ST_RUN;
                        end
                    end

                    ST_RUN: begin
                        if (!in_enable) begin
                            state <= ST_STOP;
                            pre   <= PRE_ZERO;
                        end else if (!freeze) begin
                            if (prescale_hit) begin
                                pre <= PRE_ZERO;
                                if (!at_terminal) begin
                                    out_counter_value <= stepped_value;
                                end else begin
                                    out_terminal <= 1'b1;
                                    case (in_mode)
                                        MODE_SATURATE: begin
                                            out_counter_value <= out_counter_value;
                                        end
                                        MODE_ONESHOT: begin
                                            state    <= ST_DONE;
                                            out_done <= 1'b1;
                                        end
                                        default: begin
                                            // Wrap (and the reserved 2'b11 code).
                                            out_counter_value <= stepped_value;
                                        end
                                    endcase
                                end
                            end else begin
                                pre <= pre + PRE_ONE;
                            end
                        end
                        // A frozen cycle keeps value and prescaler untouched.
                    end

                    ST_DONE: begin
                        pre      <= PRE_ZERO;
                        out_done <= 1'b1;
                    end

                    default: begin
                        state <= ST_STOP;
                        pre   <= PRE_ZERO;
                    end
                endcase
            end
        end
    end

    // MODE_WRAP documents the default branch above; keep it referenced.
    logic mode_is_wrap;
    assign mode_is_wrap = (in_mode == MODE_WRAP);

    // Explicitly unused: the wrap decode is carried by the case default.
    logic unused_ok;
    assign unused_ok = mode_is_wrap;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ctl
// Description : Directed self-checking bench for counter_ctl with a
//               cycle-level behavioural model and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctl;

    localparam int W  = 8;
    localparam int PW = 4;
    localparam int MAXV = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  load_value = '0;
    logic          load_now = 1'b0;
    logic          write_now = 1'b0;
    logic          enable = 1'b0;
    logic          dir = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [PW-1:0] prescale = '0;
    logic [W-1:0]  compare = '0;

    logic [W-1:0]  counter_value;
    logic [W-1:0]  ena;
    logic          terminal, match, done, load_ack;

    int n_assert = 0;
    int n_fail   = 0;

    counter_ctl #(.WIDTH(W), .PRE_W(PW)) dut (
        .in_clk            (clk),
        .in_rst            (rst),
        .in_load_value     (load_value),
        .in_load_now       (load_now),
        .in_write_now      (write_now),
        .in_enable         (enable),
        .in_dir            (dir),
        .in_mode           (mode),
        .in_prescale       (prescale),
        .in_compare        (compare),
        .out_counter_value (counter_value),
        .out_ena           (ena),
        .out_terminal      (terminal),
        .out_match         (match),
        .out_done          (done),
        .out_load_ack      (load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_STOP = 0, M_RUN = 1, M_DONE = 2;
    int m_state, m_val, m_pre, m_ena;
    bit m_term, m_match, m_done, m_ack;

    // Model advances on the same edges as the DUT; values in plain integers.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = M_STOP; m_val = 0; m_pre = 0; m_ena = 0;
            m_term = 0; m_match = 0; m_done = 0; m_ack = 0;
        end else begin
            bit accept, blocked, tick;
            int tv;
            accept  = load_now && (m_ena == 0);
            blocked = load_now && (m_ena != 0);
            m_match = (m_val == int'(compare));
            m_term  = 0;
            m_ack   = 0;
            tick    = 0;
            if (accept) begin
                m_val = int'(load_value);
                m_pre = 0;
                m_ack = 1;
                m_state = enable ? M_RUN : M_STOP;
            end else if (m_state == M_STOP) begin
                m_pre = 0;
                if (enable) m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                if (!enable) begin
                    m_state = M_STOP;
                    m_pre = 0;
                end else if (!blocked) begin
                    if (m_pre == int'(prescale)) begin
                        m_pre = 0;
                        tick = 1;
                    end else begin
                        m_pre = m_pre + 1;
                    end
                end
            end else begin
                m_pre = 0;
            end
            if (tick) begin
                tv = dir ? MAXV : 0;
                if (m_val != tv) begin
                    m_val = dir ? m_val + 1 : m_val - 1;
                end else begin
                    m_term = 1;
                    if (mode == 2'b10) m_state = M_DONE;
                    else if (mode != 2'b01) m_val = dir ? 0 : MAXV;
                end
            end
            m_done = (m_state == M_DONE);
            m_ena  = (write_now && !load_now) ? MAXV : 0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("value",    int'(counter_value), m_val);
            chk("ena",      int'(ena),           m_ena);
            chk("terminal", int'(terminal),      int'(m_term));
            chk("match",    int'(match),         int'(m_match));
            chk("done",     int'(done),          int'(m_done));
            chk("load_ack", int'(load_ack),      int'(m_ack));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_value", int'(counter_value), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_ena",   int'(ena), 0);
        #2 rst = 1'b0;
        step(1);
        chk("post_rst_match", int'(match), 1);
        chk("post_rst_value", int'(counter_value), 0);

        // Wrap, up, prescale 0, from FD
        load_value = 8'hFD; load_now = 1'b1; enable = 1'b1; mode = 2'b00;
        dir = 1'b1; prescale = '0;
        step(1);
        load_now = 1'b0;
        chk("wrap_load", int'(counter_value), 8'hFD);
        chk("wrap_ack",  int'(load_ack), 1);
        step(1); chk("wrap_fe", int'(counter_value), 8'hFE);
        step(1); chk("wrap_ff", int'(counter_value), 8'hFF);
        chk("wrap_ff_term", int'(terminal), 0);
        step(1); chk("wrap_00", int'(counter_value), 8'h00);
        chk("wrap_00_term", int'(terminal), 1);
        step(1); chk("wrap_01_term", int'(terminal), 0);

        // Saturate, down, from 02
        mode = 2'b01; dir = 1'b0; load_value = 8'h02; load_now = 1'b1;
        step(1);
        load_now = 1'b0;
        chk("sat_load", int'(counter_value), 8'h02);
        step(2); chk("sat_00", int'(counter_value), 8'h00);
        chk("sat_00_term", int'(terminal), 0);
        step(1); chk("sat_hold", int'(counter_value), 8'h00);
        chk("sat_term1", int'(terminal), 1);
        step(1); chk("sat_term2", int'(terminal), 1);

        // One-shot, up, prescale 2, from FE
        mode = 2'b10; dir = 1'b1; prescale = 4'd2; load_value = 8'hFE; load_now = 1'b1;
        step(1);
        load_now = 1'b0;
        step(2); chk("os_pre_wait", int'(counter_value), 8'hFE);
        step(1); chk("os_ff", int'(counter_value), 8'hFF);
        step(3); chk("os_done", int'(done), 1);
        chk("os_term", int'(terminal), 1);
        step(1); chk("os_term_end", int'(terminal), 0);
        chk("os_done_hold", int'(done), 1);
        chk("os_value_hold", int'(counter_value), 8'hFF);
        load_value = 8'h10; load_now = 1'b1;
        step(1);
        load_now = 1'b0;
        chk("os_reload", int'(counter_value), 8'h10);
        chk("os_reload_done", int'(done), 0);
        chk("os_reload_ack", int'(load_ack), 1);
        step(1); chk("os_ack_pulse", int'(load_ack), 0);

        // Bus drive blocks load for one cycle
        mode = 2'b00; prescale = '0; load_value = 8'h20; load_now = 1'b1;
        step(1);
        load_now = 1'b0; write_now = 1'b1;
        step(3);
        chk("wr_ena", int'(ena), 8'hFF);
        chk("wr_value", int'(counter_value), 8'h23);
        write_now = 1'b0; load_value = 8'h55; load_now = 1'b1;
        step(1);
        chk("frz_value", int'(counter_value), 8'h23);
        chk("frz_ena", int'(ena), 0);
        chk("frz_ack", int'(load_ack), 0);
        step(1);
        load_now = 1'b0;
        chk("ld55_value", int'(counter_value), 8'h55);
        chk("ld55_ack", int'(load_ack), 1);

        // Compare match
        compare = 8'h07; load_value = 8'h04; load_now = 1'b1;
        step(1);
        load_now = 1'b0;
        step(3);
        chk("cmp_val7", int'(counter_value), 8'h07);
        chk("cmp_early", int'(match), 0);
        step(1); chk("cmp_hit", int'(match), 1);
        step(1); chk("cmp_gone", int'(match), 0);

        // Asynchronous reset mid-count at 0x80
        load_value = 8'h7E; load_now = 1'b1;
        step(1);
        load_now = 1'b0; compare = 8'h00;
        step(2);
        chk("pre_rst_80", int'(counter_value), 8'h80);
        #1 rst = 1'b1;
        #1;
        chk("arst_value", int'(counter_value), 0);
        chk("arst_ena",   int'(ena), 0);
        chk("arst_term",  int'(terminal), 0);
        chk("arst_match", int'(match), 0);
        chk("arst_done",  int'(done), 0);
        chk("arst_ack",   int'(load_ack), 0);
        step(1);
        #2 rst = 1'b0;
        step(1);
        chk("rel_value", int'(counter_value), 0);
        chk("rel_match", int'(match), 1);
        chk("rel_term",  int'(terminal), 0);
        step(1); chk("rel_count", int'(counter_value), 8'h01);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
